// File: rtl/ad9361x2_ensm_sequencer.sv
// Dual-AD9361 ENSM pin-control sequencer: guard -> enable burst -> guard, with optional repeat and abort.
// Optional feature: define TDD_SYNC_EN to hold the end of SETUP until a tdd_sync_i rising edge.
module ad9361x2_ensm_sequencer #(
  parameter int CNT_WIDTH    = 16,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 dir,
  input  logic [1:0]           chip_sel,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic                 repeat_en,
  input  logic                 tdd_sync_i,
  output logic                 up_enable_0,
  output logic                 up_txnrx_0,
  output logic                 up_enable_1,
  output logic                 up_txnrx_1,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] GUARD_LOAD = CNT_WIDTH'(GUARD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 abort_seen;
  logic                 abort_seen_next;
  logic                 err_next;
  logic                 done_next;
  logic                 load_cfg;

  logic                 cfg_dir;
  logic [1:0]           cfg_sel;
  logic [CNT_WIDTH-1:0] cfg_len;
  logic                 cfg_rep;

  logic                 dir_eff;
  logic [1:0]           sel_eff;
  logic                 busy_next;
  logic                 en_next;
  logic                 tx_next;

`ifdef TDD_SYNC_EN
  // Input flop plus a delayed copy give a one-clock rise pulse; sync_go then
  // releases SETUP on the following edge so enable rises two edges after the
  // sync edge is first sampled.
  logic sync_q;
  logic sync_prev;
  logic sync_go;
  logic sync_rise;
  logic go_next;

  assign sync_rise = sync_q & ~sync_prev;
  assign go_next   = (state == SETUP) && (cnt == '0) && sync_rise && !abort;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
      sync_go   <= 1'b0;
    end else begin
      sync_q    <= tdd_sync_i;
      sync_prev <= sync_q;
      sync_go   <= go_next;
    end
  end
`else
  logic unused_tdd_sync;
  assign unused_tdd_sync = tdd_sync_i;
`endif

  // Counters load their full length on entry and leave the state when they reach one.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    abort_seen_next = abort_seen;
    err_next        = 1'b0;
    done_next       = 1'b0;
    load_cfg        = 1'b0;
    case (state)
      IDLE: begin
        abort_seen_next = 1'b0;
        cnt_next        = '0;
        if (start && !abort) begin
          if ((burst_len == '0) || (chip_sel == 2'b00)) begin
            err_next = 1'b1;
          end else begin
            load_cfg   = 1'b1;
            state_next = SETUP;
            cnt_next   = GUARD_LOAD;
          end
        end
      end
      SETUP: begin
        err_next = start;
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
`ifdef TDD_SYNC_EN
        else if (cnt == '0) begin
          if (sync_go) begin
            state_next = ACTIVE;
            cnt_next   = cfg_len;
          end
        end else if (cnt == CNT_ONE) begin
          cnt_next = '0;
        end
`else
        else if (cnt == CNT_ONE) begin
          state_next = ACTIVE;
          cnt_next   = cfg_len;
        end
`endif
        else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      ACTIVE: begin
        err_next = start;
        if (abort || (cnt == CNT_ONE)) begin
          state_next = HOLD;
          cnt_next   = GUARD_LOAD;
          if (abort) begin
            abort_seen_next = 1'b1;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        err_next = start;
        if (abort) begin
          abort_seen_next = 1'b1;
        end
        if (cnt == CNT_ONE) begin
          if (cfg_rep && !abort_seen && !abort) begin
            state_next = ACTIVE;
            cnt_next   = cfg_len;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pin values are computed from the next state so the pins change on the same edge as the state.
  assign dir_eff   = load_cfg ? dir : cfg_dir;
  assign sel_eff   = load_cfg ? chip_sel : cfg_sel;
  assign busy_next = (state_next != IDLE);
  assign en_next   = (state_next == ACTIVE);
  assign tx_next   = busy_next & dir_eff;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state       <= IDLE;
      cnt         <= '0;
      abort_seen  <= 1'b0;
      cfg_dir     <= 1'b0;
      cfg_sel     <= 2'b00;
      cfg_len     <= '0;
      cfg_rep     <= 1'b0;
      up_enable_0 <= 1'b0;
      up_txnrx_0  <= 1'b0;
      up_enable_1 <= 1'b0;
      up_txnrx_1  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      abort_seen <= abort_seen_next;
      if (load_cfg) begin
        cfg_dir <= dir;
        cfg_sel <= chip_sel;
        cfg_len <= burst_len;
        cfg_rep <= repeat_en;
      end
      up_enable_0 <= en_next & sel_eff[0];
      up_txnrx_0  <= tx_next & sel_eff[0];
      up_enable_1 <= en_next & sel_eff[1];
      up_txnrx_1  <= tx_next & sel_eff[1];
      busy        <= busy_next;
      done        <= done_next;
      err         <= err_next;
    end
  end

endmodule

// File: tb/tb_ad9361x2_ensm_sequencer.sv
// Scoreboard bench for ad9361x2_ensm_sequencer: a trace model predicts the pin vector for every clock.
// Build with TDD_SYNC_EN defined to exercise the sync-wait variant.
module tb_ad9361x2_ensm_sequencer;

  localparam int CW = 8;
  localparam int G  = 4;

  logic          axi_aclk = 1'b0;
  logic          axi_areset;
  logic          start;
  logic          abort;
  logic          dir;
  logic [1:0]    chip_sel;
  logic [CW-1:0] burst_len;
  logic          repeat_en;
  logic          tdd_sync_i;
  logic          up_enable_0;
  logic          up_txnrx_0;
  logic          up_enable_1;
  logic          up_txnrx_1;
  logic          busy;
  logic          done;
  logic          err;

  ad9361x2_ensm_sequencer #(
    .CNT_WIDTH   (CW),
    .GUARD_CYCLES(G)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .start      (start),
    .abort      (abort),
    .dir        (dir),
    .chip_sel   (chip_sel),
    .burst_len  (burst_len),
    .repeat_en  (repeat_en),
    .tdd_sync_i (tdd_sync_i),
    .up_enable_0(up_enable_0),
    .up_txnrx_0 (up_txnrx_0),
    .up_enable_1(up_enable_1),
    .up_txnrx_1 (up_txnrx_1),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Vector layout: {enable_0, txnrx_0, enable_1, txnrx_1, busy, done, err}
  logic [6:0] exp_q[$];
  logic [6:0] trace[$];
  int vectors     = 0;
  int miscompares = 0;
  int cycle_no    = 0;

  function automatic logic [6:0] dut_vec();
    return {up_enable_0, up_txnrx_0, up_enable_1, up_txnrx_1, busy, done, err};
  endfunction

  function automatic logic [6:0] mk(bit en, bit tx, logic [1:0] sel);
    return {en & sel[0], tx & sel[0], en & sel[1], tx & sel[1], 3'b100};
  endfunction

  function automatic int setupLen(int sync_d);
`ifdef TDD_SYNC_EN
    return G + sync_d + 2;
`else
    return G + 0 * sync_d;
`endif
  endfunction

  function automatic logic sync_junk();
`ifdef TDD_SYNC_EN
    return 1'b0;
`else
    return 1'($urandom);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: one expected vector per clock while the scoreboard holds entries.
  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        checkOutput($sformatf("pins@%0d", cycle_no), dut_vec(), exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected trace: trace[t] is the output during clock t after the accepting edge.
  task automatic buildTrace(input bit d, input logic [1:0] sel, input int len, input bit rep,
                            input int setup_len, input int abort_at);
    int  t = 1;
    bit  ab = 0;
    bit  ab_setup = 0;
    trace.delete();
    trace.push_back(7'b0);
    for (int i = 0; i < setup_len; i++) begin
      trace.push_back(mk(1'b0, d, sel));
      if (abort_at == t) ab_setup = 1;
      t++;
      if (ab_setup) break;
    end
    if (!ab_setup) begin
      do begin
        for (int i = 0; i < len; i++) begin
          trace.push_back(mk(1'b1, d, sel));
          if (abort_at == t) begin
            ab = 1;
            t++;
            break;
          end
          t++;
        end
        for (int i = 0; i < G; i++) begin
          trace.push_back(mk(1'b0, d, sel));
          if (abort_at == t) ab = 1;
          t++;
        end
      end while (rep && !ab);
      trace.push_back(7'b0000010);
    end else begin
      trace.push_back(7'b0);
    end
  endtask

  // spur: -1 none, -2 random busy cycle, >0 that cycle
  task automatic applyStimulus(input bit d, input logic [1:0] sel, input int len, input bit rep,
                               input int abort_at, input int spur, input int sync_d);
    int n;
    int s;
    logic [6:0] v;
    buildTrace(d, sel, len, rep, setupLen(sync_d), abort_at);
    n = trace.size() - 1;
    s = spur;
    if (spur == -2) s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n - 1)) : -1;
    if (s == abort_at) s = -1;
    if (s > 0 && s + 1 <= n) begin
      v = trace[s + 1];
      v[0] = 1'b1;
      trace[s + 1] = v;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge axi_aclk);
      start = (c == 0) || (c == s);
      abort = (c > 0) && (c == abort_at);
      if (c == 0) begin
        dir = d; chip_sel = sel; burst_len = CW'(len); repeat_en = rep;
      end else begin
        dir = 1'($urandom); chip_sel = 2'($urandom); burst_len = CW'($urandom); repeat_en = 1'($urandom);
      end
`ifdef TDD_SYNC_EN
      tdd_sync_i = (c > 0) && (c >= G + sync_d);
`else
      tdd_sync_i = sync_junk();
`endif
      exp_q.push_back(trace[c + 1]);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge axi_aclk);
      start = 0; abort = 0; tdd_sync_i = sync_junk();
      exp_q.push_back(7'b0);
    end
  endtask

  task automatic applyBad(input bit with_abort);
    @(negedge axi_aclk);
    start = 1; abort = with_abort; tdd_sync_i = sync_junk();
    dir = 1'($urandom); repeat_en = 1'($urandom);
    if (with_abort) begin
      chip_sel = 2'($urandom_range(1, 3)); burst_len = CW'($urandom_range(1, 20));
    end else if ($urandom_range(0, 1) == 1) begin
      chip_sel = 2'($urandom_range(1, 3)); burst_len = '0;
    end else begin
      chip_sel = 2'b00; burst_len = CW'($urandom_range(1, 20));
    end
    exp_q.push_back(with_abort ? 7'b0 : 7'b0000001);
  endtask

  task automatic resetMidBurst();
    int sl = setupLen(2);
    buildTrace(1'b1, 2'b11, 10, 1'b0, sl, -1);
    for (int c = 0; c < sl + 3; c++) begin
      @(negedge axi_aclk);
      start = (c == 0); abort = 0;
      dir = 1; chip_sel = 2'b11; burst_len = CW'(10); repeat_en = 0;
`ifdef TDD_SYNC_EN
      tdd_sync_i = (c > 0) && (c >= G + 2);
`else
      tdd_sync_i = sync_junk();
`endif
      exp_q.push_back(trace[c + 1]);
    end
    @(negedge axi_aclk);
    start = 0;
    #2 axi_areset = 1;
    #1 checkOutput("async_reset_mid_active", dut_vec(), 7'b0);
    repeat (2) @(posedge axi_aclk);
    #1 checkOutput("held_in_reset", dut_vec(), 7'b0);
    axi_areset = 0;
  endtask

  initial begin
    int sl;
    int len;
    bit rep;
    int ab;
    axi_areset = 1; start = 0; abort = 0; dir = 0; chip_sel = 0;
    burst_len = '0; repeat_en = 0; tdd_sync_i = 0;
    #3 checkOutput("reset_state_async", dut_vec(), 7'b0);
    repeat (3) @(posedge axi_aclk);
    #1 checkOutput("reset_state", dut_vec(), 7'b0);
    axi_areset = 0;

    applyStimulus(1'b1, 2'b11, 10, 1'b0, -1, -1, 7);
    idleCycles(2);
    sl = setupLen(0);
    applyStimulus(1'b1, 2'b01, 3, 1'b1, sl + 3 + G + 2, -1, 0);
    applyBad(1'b0);
    applyStimulus(1'b0, 2'b11, 6, 1'b0, -1, setupLen(1) + 2, 1);
    applyBad(1'b1);
    idleCycles(1);
    applyStimulus(1'b1, 2'b10, 5, 1'b0, 2, -1, 0);
    applyStimulus(1'b1, 2'b01, 4, 1'b1, setupLen(0) + 4 + G, -1, 0);
    applyStimulus(1'b0, 2'b10, 255, 1'b0, -1, -1, 1);
    idleCycles(1);
    resetMidBurst();
    applyStimulus(1'b1, 2'b11, 3, 1'b0, -1, -1, 0);

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 12);
      rep = 1'($urandom);
      ab  = $urandom_range(0, 2);
      sl  = $urandom_range(0, 5);
      if (rep || ab != 0) ab = $urandom_range(1, setupLen(sl) + 2 * len + 2 * G);
      else ab = -1;
      if ($urandom_range(0, 5) == 0) applyBad($urandom_range(0, 1) == 1);
      applyStimulus(1'($urandom), 2'($urandom_range(1, 3)), len, rep, ab, -2, sl);
      idleCycles($urandom_range(0, 2));
    end

    idleCycles(2);
    @(posedge axi_aclk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ad9361x2_ensm_sequencer.md
AD9361X2_ENSM_SEQUENCER -- requirements
Module: ad9361x2_ensm_sequencer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, setting the width of the burst length and cycle counters.
REQ-002 SHALL have parameter GUARD_CYCLES, default 8, setting the txnrx setup and hold time in clocks (legal range 1..2^CNT_WIDTH-1).
REQ-003 SHALL have port axi_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port axi_areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports start, input, 1 (request pulse) and abort, input, 1 (cancel pulse).
REQ-006 SHALL have ports dir, input, 1 (1=TX, 0=RX) and chip_sel, input, 2 (bit0=chip 0, bit1=chip 1).
REQ-007 SHALL have ports burst_len, input, CNT_WIDTH (enable-high length in clocks) and repeat_en, input, 1.
REQ-008 SHALL have port tdd_sync_i, input, 1: external TDD sync.
REQ-009 SHALL have ports up_enable_0, up_txnrx_0, up_enable_1, up_txnrx_1, each output, 1: AD9361 ENSM pin-control lines.
REQ-010 SHALL have ports busy, output, 1; done, output, 1 (one-clock pulse); err, output, 1 (one-clock pulse).

Function
REQ-011 SHALL implement states IDLE, SETUP, ACTIVE, HOLD, with all outputs registered.
REQ-012 IDLE: all up_* low, busy low; start latches dir, chip_sel, burst_len and repeat_en, and the block enters SETUP on the next edge.
REQ-013 start with burst_len==0 or chip_sel==0 SHALL pulse err one clock and stay in IDLE.
REQ-014 start outside IDLE SHALL be ignored and SHALL pulse err one clock; the latched config is unchanged.
REQ-015 start and abort together in IDLE: abort wins, no transition, no err.
REQ-016 SETUP: up_txnrx_x = latched dir for selected chips only, up_enable_x low, for exactly GUARD_CYCLES clocks, then ACTIVE.
REQ-017 ACTIVE: up_enable_x high for selected chips for exactly burst_len clocks, with up_txnrx_x held; then HOLD.
REQ-018 HOLD: up_enable_x low, up_txnrx_x held, for exactly GUARD_CYCLES clocks.
REQ-019 HOLD exit with repeat_en latched and no abort seen SHALL go to ACTIVE, reusing the latched burst_len.
REQ-020 HOLD exit otherwise SHALL go to IDLE, pulse done on the first IDLE clock, and drive up_txnrx_x low.
REQ-021 Unselected chips' up_enable/up_txnrx SHALL stay low in every state.
REQ-022 busy SHALL be high in SETUP, ACTIVE and HOLD.
REQ-023 abort in SETUP SHALL go to IDLE next edge, with no done and txnrx low.
REQ-024 abort in ACTIVE SHALL go to HOLD next edge (enable drops), then complete HOLD, go to IDLE and pulse done.
REQ-025 abort in HOLD SHALL cancel any repeat; HOLD completes normally.
REQ-026 Counters SHALL load terminal values on state entry and count down with no wrap; burst_len = 2^CNT_WIDTH-1 is legal.
REQ-027 up_enable_x SHALL never be high in a clock where up_txnrx_x changes.

Reset
REQ-028 axi_areset high SHALL immediately force IDLE, all outputs 0 and counters 0, regardless of the clock.
REQ-029 Reset mid-burst SHALL drop up_enable_x and up_txnrx_x asynchronously, with no done pulse on release.
REQ-030 After deassertion the block SHALL accept start on the first clock edge.

Configuration
REQ-031 Macro TDD_SYNC_EN defined: when the SETUP count expires, the block SHALL wait in SETUP until a tdd_sync_i rising edge, detected through one register stage, then enter ACTIVE on the following edge; this applies to SETUP only, and repeats via HOLD do not wait. Abort during the wait follows REQ-023.
REQ-032 Macro TDD_SYNC_EN undefined: tdd_sync_i SHALL be ignored, and the edge-detect register SHALL not be present.

Verification
REQ-033 GUARD_CYCLES=4, dir=1, chip_sel=3, burst_len=10, start at cycle 0 -> txnrx_0/1 high cycles 1-18, enable_0/1 high cycles 5-14, done at cycle 19, busy high cycles 1-18.
REQ-034 chip_sel=1, repeat_en=1, burst_len=3, abort at the 2nd ACTIVE cycle of the 2nd burst -> exactly 2 enable pulses (3, 2 clocks), done pulse, chip 1 pins always 0.
REQ-035 start with burst_len=0 -> err pulse 1 clock, busy stays 0; start during ACTIVE -> err pulse, burst unaffected.
REQ-036 axi_areset asserted between edges in ACTIVE -> all up_* 0 before the next edge, no done; start after release runs a full sequence.
REQ-037 TDD_SYNC_EN defined, tdd_sync_i rising 7 clocks after guard expiry -> enable rises exactly 2 edges after the sync edge; not defined -> timing identical to REQ-033.
